// File: rtl/dff_pkg.sv
// dff_pkg: shared constants for the d_ff register family.
//   WIDTH_MAX       - largest supported data width
//   STAGES_MAX      - largest supported pipeline depth
//   RST_VAL_DEFAULT - reset value used when the instantiator gives none
`timescale 1ns/1ps
package dff_pkg;

    localparam int WIDTH_MAX  = 64;
    localparam int STAGES_MAX = 8;

    localparam logic [WIDTH_MAX-1:0] RST_VAL_DEFAULT = 64'h0000_0000_0000_0000;

endpackage : dff_pkg

// File: rtl/d_ff_stage.sv
// d_ff_stage: one WIDTH-wide register with synchronous active-low reset.
// Ports:
//   clk - rising-edge clock
//   r   - synchronous reset, active low; loads RST_VAL
//   d   - data captured on each rising edge while r is high
//   q   - registered output
`timescale 1ns/1ps
module d_ff_stage
    import dff_pkg::*;
#(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = RST_VAL_DEFAULT[WIDTH-1:0]
) (
    input  logic             clk,
    input  logic             r,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_r;

    // Storage register: reset has priority over the data sample.
    always_ff @(posedge clk) begin
        if (!r) begin
            q_r <= RST_VAL;
        end else begin
            q_r <= d;
        end
    end

    assign q = q_r;

endmodule : d_ff_stage

// File: rtl/d_ff.sv
// d_ff: parameterised D register with an optional re-timing pipeline.
// Data is delayed by exactly STAGES rising edges; a low r at an edge loads
// RST_VAL into every stage, discarding any data in flight.
// Ports:
//   clk - rising-edge clock, the only clock
//   r   - synchronous reset, active low
//   d   - WIDTH-bit data input
//   q   - WIDTH-bit output, driven straight from the last stage
`timescale 1ns/1ps
module d_ff
    import dff_pkg::*;
#(
    parameter int               WIDTH   = 1,
    parameter int               STAGES  = 1,
    parameter logic [WIDTH-1:0] RST_VAL = RST_VAL_DEFAULT[WIDTH-1:0]
) (
    input  logic             clk,
    input  logic             r,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reject configurations outside the supported range at elaboration.
    if ((WIDTH < 1) || (WIDTH > WIDTH_MAX)) begin : g_bad_width
        $error("d_ff: WIDTH %0d outside 1..%0d", WIDTH, WIDTH_MAX);
    end
    if ((STAGES < 1) || (STAGES > STAGES_MAX)) begin : g_bad_stages
        $error("d_ff: STAGES %0d outside 1..%0d", STAGES, STAGES_MAX);
    end

    // chain_s[0] is the input; chain_s[k+1] is the output of stage k.
    logic [STAGES:0][WIDTH-1:0] chain_s;

    assign chain_s[0] = d;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        d_ff_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk (clk),
            .r   (r),
            .d   (chain_s[k]),
            .q   (chain_s[k+1])
        );
    end

    assign q = chain_s[STAGES];

endmodule : d_ff

// File: tb/tb_d_ff.sv
// tb_d_ff: randomized self-checking bench for d_ff. Four configurations share
// one clock and one reset; each gets its own data. The reference model keeps
// the full history of sampled (r, d) pairs and derives q from the rule
// "q = d sampled STAGES edges ago, unless any of the last STAGES edges reset".
`timescale 1ns/1ps
module tb_d_ff;

    localparam logic [63:0] RV_B = 64'h0000_0000_0000_00A5;
    localparam logic [63:0] RV_D = 64'hDEAD_BEEF_0123_4567;

    logic        clk;
    logic        r;
    logic        d_a, q_a;
    logic [7:0]  d_b, q_b;
    logic [7:0]  d_c, q_c;
    logic [63:0] d_d, q_d;

    int vectors;
    int miscompares;

    typedef struct packed {
        logic        r;
        logic [63:0] d0;
        logic [63:0] d1;
        logic [63:0] d2;
        logic [63:0] d3;
    } ev_t;

    ev_t hist[$];

    // Default configuration: 1 bit, 1 stage, reset to 0.
    d_ff u_a (.clk(clk), .r(r), .d(d_a), .q(q_a));

    d_ff #(.WIDTH(8), .STAGES(1), .RST_VAL(8'hA5)) u_b (
        .clk(clk), .r(r), .d(d_b), .q(q_b));

    d_ff #(.WIDTH(8), .STAGES(3)) u_c (
        .clk(clk), .r(r), .d(d_c), .q(q_c));

    d_ff #(.WIDTH(64), .STAGES(8), .RST_VAL(64'hDEAD_BEEF_0123_4567)) u_d (
        .clk(clk), .r(r), .d(d_d), .q(q_d));

    // Clock: period 2 ns, rising edges at 1, 3, 5, ...
    initial begin
        clk = 1'b0;
        forever #1 clk = ~clk;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model for configuration idx; known=0 while q is still undefined.
    function automatic void model(input int idx, output logic [63:0] exp, output bit known);
        int s;
        int n;
        logic [63:0] rv;
        ev_t ev;
        case (idx)
            0:       begin s = 1; rv = 64'd0; end
            1:       begin s = 1; rv = RV_B;  end
            2:       begin s = 3; rv = 64'd0; end
            default: begin s = 8; rv = RV_D;  end
        endcase
        n = hist.size() - 1;
        known = 1'b0;
        exp = 64'd0;
        for (int k = 0; k < s; k++) begin
            if (n - k < 0) return;
            if (!hist[n-k].r) begin
                exp = rv;
                known = 1'b1;
                return;
            end
        end
        ev = hist[n-s+1];
        case (idx)
            0:       exp = ev.d0;
            1:       exp = ev.d1;
            2:       exp = ev.d2;
            default: exp = ev.d3;
        endcase
        known = 1'b1;
    endfunction

    task automatic check_all(input string tag);
        logic [63:0] exp;
        bit known;
        model(0, exp, known);
        if (known) check_eq({tag, "/a"}, {63'd0, q_a}, exp);
        model(1, exp, known);
        if (known) check_eq({tag, "/b"}, {56'd0, q_b}, exp);
        model(2, exp, known);
        if (known) check_eq({tag, "/c"}, {56'd0, q_c}, exp);
        model(3, exp, known);
        if (known) check_eq({tag, "/d"}, q_d, exp);
    endtask

    // Apply one edge's inputs (called away from the rising edge), optionally
    // glitch r low between the edges, then check just before the next inputs.
    task automatic step(input string tag, input logic rr, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] c,
                        input logic [63:0] dd, input bit glitch);
        ev_t ev;
        r   = rr;
        d_a = a[0];
        d_b = b[7:0];
        d_c = c[7:0];
        d_d = dd;
        ev.r  = rr;
        ev.d0 = {63'd0, a[0]};
        ev.d1 = {56'd0, b[7:0]};
        ev.d2 = {56'd0, c[7:0]};
        ev.d3 = dd;
        hist.push_back(ev);
        @(posedge clk);
        if (glitch) begin
            #0.2 r = 1'b0;
            #0.5 r = 1'b1;
        end
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        r = 1'b1; d_a = 1'b0; d_b = 8'h00; d_c = 8'h00; d_d = 64'd0;

        // Reset sequence, including reset priority over d=1 / all-ones data.
        step("rst0",  1'b0, 64'd1, 64'hFF, 64'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        step("rel0",  1'b1, 64'd0, 64'h00, 64'h00, 64'd0, 1'b0);
        step("rst1",  1'b0, 64'd1, 64'h5A, 64'h5A, 64'h1234, 1'b0);
        // Capture after release.
        step("cap1",  1'b1, 64'd1, 64'h3C, 64'h3C, 64'hCAFE_F00D_0000_0001, 1'b0);
        step("cap2",  1'b1, 64'd0, 64'h00, 64'h00, 64'd0, 1'b0);
        step("cap3",  1'b1, 64'd0, 64'h00, 64'h00, 64'd0, 1'b0);
        step("cap4",  1'b1, 64'd0, 64'h00, 64'h00, 64'd0, 1'b0);
        // Glitch immunity: r pulses low between edges only.
        step("glit0", 1'b1, 64'd1, 64'h77, 64'h77, 64'h7777, 1'b1);
        step("glit1", 1'b1, 64'd1, 64'h78, 64'h78, 64'h7778, 1'b1);
        // Reset mid-pipeline: 0x11, 0x22 loaded then discarded.
        step("mid0",  1'b1, 64'd1, 64'h11, 64'h11, 64'h11, 1'b0);
        step("mid1",  1'b1, 64'd0, 64'h22, 64'h22, 64'h22, 1'b0);
        step("mid2",  1'b0, 64'd1, 64'h33, 64'h33, 64'h33, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step("mid_drain", 1'b1, 64'd0, 64'h00, 64'h00, 64'd0, 1'b0);
        end

        // Randomized traffic with occasional resets and glitches.
        for (int i = 0; i < 400; i++) begin
            logic        rr;
            logic [63:0] rd;
            rr = ($urandom_range(0, 11) == 0) ? 1'b0 : 1'b1;
            rd = {$urandom, $urandom};
            step("rand", rr, {63'd0, rd[3]}, {56'd0, rd[15:8]}, {56'd0, rd[23:16]},
                 {$urandom, $urandom}, ($urandom_range(0, 7) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_d_ff
